pipe_stall_sched: RTL and testbench

Stateful stall/flush scheduler for the RV64 in-order pipeline (stages IFP, IFR, IDP, IDR, IDC, EXA, EXB). It replaces purely combinational hazard gating with a small FSM that resolves simultaneous hazard requests by priority. The FSM covers multi-cycle MDU ops, data-cache wait, load-use bubbles and fence.i drains. It also holds a branch/fence redirect to fetch until IFP accepts it, over a valid/ready handshake.

---
 rtl/pipe_stall_sched_pkg.sv | 34 +++
 rtl/pipe_stall_sched.sv | 144 ++++++++++++++
 tb/tb_pipe_stall_sched.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_sched_pkg.sv
// Shared pipeline types for the in-order stall/flush scheduler: FSM state,
// the per-stage stall/flush bundle and the canned bundle patterns.
package pipe_stall_sched_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        RUN,
        MDU_WAIT,
        REDIR_WAIT,
        DRAIN
    } pipe_sched_state_t;

    typedef struct packed {
        logic stall_ifp;
        logic stall_ifr;
        logic stall_idp;
        logic stall_idr;
        logic stall_exa;
        logic stall_exb;
        logic flush_ifr;
        logic flush_idr;
        logic flush_idc;
        logic flush_exa;
    } stage_ctrl_t;

    // Bit order follows the struct: six stalls (IFP..EXB), then four flushes (IFR..EXA).
    localparam stage_ctrl_t CTRL_NONE        = 10'b000000_0000;
    localparam stage_ctrl_t CTRL_STALL_ALL   = 10'b111111_0000;
    localparam stage_ctrl_t CTRL_HOLD_FRONT  = 10'b111100_0001;
    localparam stage_ctrl_t CTRL_FLUSH_FRONT = 10'b000000_1110;
    localparam stage_ctrl_t CTRL_FLUSH_ALL   = 10'b000000_1111;

endpackage

// File: rtl/pipe_stall_sched.sv
// Stall/flush scheduler: priority-resolves hazards, waits out MDU ops and
// fence.i drains, and holds fetch redirects until IFP accepts them.
module pipe_stall_sched
    import pipe_stall_sched_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_taken_EXB,
    input  logic [XLEN-1:0] branch_target_EXB,
    input  logic            no_forwarding_data,
    input  logic            mdu_start_EXA,
    input  logic            mdu_done,
    input  logic            mem_req_MEM,
    input  logic            mem_ready,
    input  logic            fence_i_ID,
    input  logic [XLEN-1:0] fence_pc_ID,
    input  logic            redirect_ready_IFP,
    output logic            stall_IFP,
    output logic            stall_IFR,
    output logic            stall_IDP,
    output logic            stall_IDR,
    output logic            stall_EXA,
    output logic            stall_EXB,
    output logic            flush_IFR,
    output logic            flush_IDR,
    output logic            flush_IDC,
    output logic            flush_EXA,
    output logic            redirect_valid_IFP,
    output logic [XLEN-1:0] redirect_target_IFP,
    output logic            busy
);

    pipe_sched_state_t state, state_d;
    logic [XLEN-1:0]   redir_target, redir_target_d;
    logic [3:0]        drain_cnt, drain_cnt_d;

    stage_ctrl_t       ctrl;
    logic              redir_valid;
    logic [XLEN-1:0]   redir_tgt;
    logic              mem_stall;
    logic [XLEN-1:0]   fence_target;

    assign mem_stall    = mem_req_MEM & ~mem_ready;
    assign fence_target = fence_pc_ID + XLEN'(4);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        ctrl           = CTRL_NONE;
        redir_valid    = 1'b0;
        redir_tgt      = '0;
        state_d        = state;
        redir_target_d = redir_target;
        drain_cnt_d    = drain_cnt;

        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    ctrl = CTRL_STALL_ALL;
                end else if (branch_taken_EXB) begin
                    // Younger requests are flushed along with their stages.
                    ctrl        = CTRL_FLUSH_ALL;
                    redir_valid = 1'b1;
                    redir_tgt   = branch_target_EXB;
                    if (!redirect_ready_IFP) begin
                        redir_target_d = branch_target_EXB;
                        state_d        = REDIR_WAIT;
                    end
                end else if (mdu_start_EXA) begin
                    state_d = MDU_WAIT;
                end else if (no_forwarding_data) begin
                    ctrl = CTRL_HOLD_FRONT;
                end else if (fence_i_ID) begin
                    ctrl        = CTRL_HOLD_FRONT;
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                    state_d     = DRAIN;
                end
            end

            MDU_WAIT: begin
                if (mem_stall || !mdu_done) ctrl = CTRL_STALL_ALL;
                if (mdu_done) state_d = RUN;
            end

            REDIR_WAIT: begin
                // The handshake may complete even while the data cache stalls.
                redir_valid = 1'b1;
                redir_tgt   = redir_target;
                ctrl        = mem_stall ? CTRL_STALL_ALL : CTRL_FLUSH_FRONT;
                if (redirect_ready_IFP) state_d = RUN;
            end

            DRAIN: begin
                if (mem_stall) begin
                    ctrl = CTRL_STALL_ALL;
                end else if (drain_cnt == 4'd0) begin
                    ctrl        = CTRL_HOLD_FRONT | CTRL_FLUSH_FRONT;
                    redir_valid = 1'b1;
                    redir_tgt   = fence_target;
                    if (redirect_ready_IFP) begin
                        state_d = RUN;
                    end else begin
                        redir_target_d = fence_target;
                        state_d        = REDIR_WAIT;
                    end
                end else begin
                    ctrl        = CTRL_HOLD_FRONT;
                    drain_cnt_d = drain_cnt - 4'd1;
                end
            end

            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state        <= RUN;
            redir_target <= '0;
            drain_cnt    <= '0;
        end else begin
            state        <= state_d;
            redir_target <= redir_target_d;
            drain_cnt    <= drain_cnt_d;
        end
    end

    assign stall_IFP           = ctrl.stall_ifp;
    assign stall_IFR           = ctrl.stall_ifr;
    assign stall_IDP           = ctrl.stall_idp;
    assign stall_IDR           = ctrl.stall_idr;
    assign stall_EXA           = ctrl.stall_exa;
    assign stall_EXB           = ctrl.stall_exb;
    assign flush_IFR           = ctrl.flush_ifr;
    assign flush_IDR           = ctrl.flush_idr;
    assign flush_IDC           = ctrl.flush_idc;
    assign flush_EXA           = ctrl.flush_exa;
    assign redirect_valid_IFP  = redir_valid;
    assign redirect_target_IFP = redir_tgt;
    assign busy                = (state != RUN);

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Scoreboard bench for pipe_stall_sched: a behavioural model predicts each
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_pipe_stall_sched;

    localparam int unsigned DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken_EXB;
    logic [63:0] branch_target_EXB;
    logic        no_forwarding_data;
    logic        mdu_start_EXA;
    logic        mdu_done;
    logic        mem_req_MEM;
    logic        mem_ready;
    logic        fence_i_ID;
    logic [63:0] fence_pc_ID;
    logic        redirect_ready_IFP;
    logic        stall_IFP, stall_IFR, stall_IDP, stall_IDR, stall_EXA, stall_EXB;
    logic        flush_IFR, flush_IDR, flush_IDC, flush_EXA;
    logic        redirect_valid_IFP;
    logic [63:0] redirect_target_IFP;
    logic        busy;

    always #5 clk = ~clk;

    pipe_stall_sched #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk                (clk),
        .rst                (rst),
        .branch_taken_EXB   (branch_taken_EXB),
        .branch_target_EXB  (branch_target_EXB),
        .no_forwarding_data (no_forwarding_data),
        .mdu_start_EXA      (mdu_start_EXA),
        .mdu_done           (mdu_done),
        .mem_req_MEM        (mem_req_MEM),
        .mem_ready          (mem_ready),
        .fence_i_ID         (fence_i_ID),
        .fence_pc_ID        (fence_pc_ID),
        .redirect_ready_IFP (redirect_ready_IFP),
        .stall_IFP          (stall_IFP),
        .stall_IFR          (stall_IFR),
        .stall_IDP          (stall_IDP),
        .stall_IDR          (stall_IDR),
        .stall_EXA          (stall_EXA),
        .stall_EXB          (stall_EXB),
        .flush_IFR          (flush_IFR),
        .flush_IDR          (flush_IDR),
        .flush_IDC          (flush_IDC),
        .flush_EXA          (flush_EXA),
        .redirect_valid_IFP (redirect_valid_IFP),
        .redirect_target_IFP(redirect_target_IFP),
        .busy               (busy)
    );

    typedef struct {
        logic        rst;
        logic        br;
        logic [63:0] br_tgt;
        logic        nofwd;
        logic        mdu_start;
        logic        mdu_done;
        logic        mem_req;
        logic        mem_ready;
        logic        fence;
        logic [63:0] fence_pc;
        logic        ready;
    } stim_t;

    // stall = {IFP,IFR,IDP,IDR,EXA,EXB}, flush = {IFR,IDR,IDC,EXA}
    typedef struct packed {
        logic [5:0]  stall;
        logic [3:0]  flush;
        logic        rv;
        logic [63:0] rt;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   vec_id      = 0;

    // Reference model: pending work tracked as flags and a countdown of drain cycles left.
    bit          m_mdu_pending;
    bit          m_redir_pending;
    logic [63:0] m_redir_pc;
    int          m_drain_left;

    task automatic model_step(input stim_t s, output exp_t e);
        bit ms;
        ms = s.mem_req & ~s.mem_ready;
        e = '0;
        e.busy = m_mdu_pending | m_redir_pending | (m_drain_left != 0);
        if (m_redir_pending) begin
            e.rv = 1'b1;
            e.rt = m_redir_pc;
            if (ms) e.stall = 6'b111111;
            else    e.flush = 4'b1110;
            if (s.ready) m_redir_pending = 1'b0;
        end else if (m_mdu_pending) begin
            if (ms || !s.mdu_done) e.stall = 6'b111111;
            if (s.mdu_done) m_mdu_pending = 1'b0;
        end else if (m_drain_left != 0) begin
            if (ms) begin
                e.stall = 6'b111111;
            end else begin
                e.stall = 6'b111100;
                e.flush = 4'b0001;
                if (m_drain_left == 1) begin
                    e.flush = 4'b1111;
                    e.rv    = 1'b1;
                    e.rt    = s.fence_pc + 64'd4;
                    if (!s.ready) begin
                        m_redir_pending = 1'b1;
                        m_redir_pc      = e.rt;
                    end
                end
                m_drain_left = m_drain_left - 1;
            end
        end else if (ms) begin
            e.stall = 6'b111111;
        end else if (s.br) begin
            e.flush = 4'b1111;
            e.rv    = 1'b1;
            e.rt    = s.br_tgt;
            if (!s.ready) begin
                m_redir_pending = 1'b1;
                m_redir_pc      = s.br_tgt;
            end
        end else if (s.mdu_start) begin
            m_mdu_pending = 1'b1;
        end else if (s.nofwd) begin
            e.stall = 6'b111100;
            e.flush = 4'b0001;
        end else if (s.fence) begin
            e.stall = 6'b111100;
            e.flush = 4'b0001;
            m_drain_left = int'(DRAIN);
        end
        if (s.rst) begin
            m_mdu_pending   = 1'b0;
            m_redir_pending = 1'b0;
            m_redir_pc      = '0;
            m_drain_left    = 0;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.br = 0; s.br_tgt = '0; s.nofwd = 0; s.mdu_start = 0;
        s.mdu_done = 0; s.mem_req = 0; s.mem_ready = 0; s.fence = 0;
        s.fence_pc = '0; s.ready = 0;
        return s;
    endfunction

    task automatic apply(input stim_t s, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = s.rst;
        branch_taken_EXB   = s.br;
        branch_target_EXB  = s.br_tgt;
        no_forwarding_data = s.nofwd;
        mdu_start_EXA      = s.mdu_start;
        mdu_done           = s.mdu_done;
        mem_req_MEM        = s.mem_req;
        mem_ready          = s.mem_ready;
        fence_i_ID         = s.fence;
        fence_pc_ID        = s.fence_pc;
        redirect_ready_IFP = s.ready;
        model_step(s, e);
        if (chk) begin
            exp_q.push_back(e);
            id_q.push_back(vec_id);
        end
        vec_id++;
    endtask

    exp_t mon_exp, mon_act;
    int   mon_id;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_id  = id_q.pop_front();
            mon_act.stall = {stall_IFP, stall_IFR, stall_IDP, stall_IDR, stall_EXA, stall_EXB};
            mon_act.flush = {flush_IFR, flush_IDR, flush_IDC, flush_EXA};
            mon_act.rv    = redirect_valid_IFP;
            mon_act.rt    = redirect_target_IFP;
            mon_act.busy  = busy;
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL vec%0d: got stall=%b flush=%b rv=%b rt=%h busy=%b, want stall=%b flush=%b rv=%b rt=%h busy=%b",
                         mon_id, mon_act.stall, mon_act.flush, mon_act.rv, mon_act.rt, mon_act.busy,
                         mon_exp.stall, mon_exp.flush, mon_exp.rv, mon_exp.rt, mon_exp.busy);
            end
        end
    end

    initial begin
        stim_t s;
        m_mdu_pending = 0; m_redir_pending = 0; m_redir_pc = '0; m_drain_left = 0;

        // Reset: first cycle has unknown pre-reset state, so only later cycles are checked.
        s = idle(); s.rst = 1;
        apply(s, 0);
        apply(s, 1);
        s = idle();
        apply(s, 1);
        apply(s, 1);

        // Branch with IFP not ready for three cycles, accepted on the fourth.
        s = idle(); s.br = 1; s.br_tgt = 64'h0000_0000_8000_0040;
        apply(s, 1);
        s = idle();
        apply(s, 1);
        apply(s, 1);
        s.ready = 1;
        apply(s, 1);
        s = idle();
        apply(s, 1);

        // MDU issued at t, done at t+5.
        s = idle(); s.mdu_start = 1;
        apply(s, 1);
        s = idle();
        for (int i = 0; i < 4; i++) apply(s, 1);
        s.mdu_done = 1;
        apply(s, 1);
        s = idle();
        apply(s, 1);

        // Simultaneous branch, load-use and MDU issue: branch wins alone.
        s = idle(); s.br = 1; s.br_tgt = 64'h1234_5678_9abc_def0;
        s.nofwd = 1; s.mdu_start = 1; s.ready = 1;
        apply(s, 1);
        s = idle();
        apply(s, 1);

        // Data-cache stall masks a held branch for two cycles.
        s = idle(); s.br = 1; s.br_tgt = 64'h0000_0000_0000_2000; s.ready = 1;
        s.mem_req = 1; s.mem_ready = 0;
        apply(s, 1);
        apply(s, 1);
        s.mem_req = 0;
        apply(s, 1);
        s = idle();
        apply(s, 1);

        // Load-use bubble.
        s = idle(); s.nofwd = 1;
        apply(s, 1);

        // fence.i drain with IFP ready, then one at the top of the address space (wrap).
        s = idle(); s.fence = 1; s.fence_pc = 64'h1000; s.ready = 1;
        for (int i = 0; i < 1 + int'(DRAIN); i++) apply(s, 1);
        s = idle();
        apply(s, 1);
        s = idle(); s.fence = 1; s.fence_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        for (int i = 0; i < 1 + int'(DRAIN); i++) apply(s, 1);
        s.ready = 1;
        apply(s, 1);
        s = idle();
        apply(s, 1);

        // Reset while a redirect is pending drops it.
        s = idle(); s.br = 1; s.br_tgt = 64'hdead_beef_0000_0100;
        apply(s, 1);
        s = idle(); s.rst = 1;
        apply(s, 1);
        s = idle();
        apply(s, 1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            s.rst       = ($urandom_range(0, 99) < 2);
            s.br        = ($urandom_range(0, 99) < 10);
            s.br_tgt    = {$urandom(), $urandom()};
            s.nofwd     = ($urandom_range(0, 99) < 15);
            s.mdu_start = ($urandom_range(0, 99) < 10);
            s.mdu_done  = ($urandom_range(0, 99) < 20);
            s.mem_req   = ($urandom_range(0, 99) < 30);
            s.mem_ready = ($urandom_range(0, 99) < 50);
            s.fence     = ($urandom_range(0, 99) < 8);
            s.fence_pc  = {$urandom(), $urandom()};
            s.ready     = ($urandom_range(0, 99) < 50);
            apply(s, 1);
        end

        s = idle();
        apply(s, 0);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
